// File: rtl/seq_alu_pkg.sv
// Shared opcodes and FSM state type for seq_alu.
// The BUSY state exists only when SEQ_ALU_MULDIV_EN is defined.
package seq_alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_NOR  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_LUI  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MULU = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;

`ifdef SEQ_ALU_MULDIV_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;
`else
    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } state_e;
`endif

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned unit: shift-add multiplier and restoring divider, one bit per cycle.
// start_i loads operands; done_o flags the final iteration with the result on lo_o/hi_o.
module seq_alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q;
    logic             div_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   sum, shl, diff;

    // hi holds the partial product / remainder, lo the multiplier / dividend-then-quotient.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        sum  = {1'b0, hi_q} + {1'b0, b_q};
        shl  = {hi_q, lo_q[WIDTH-1]};
        diff = shl - {1'b0, b_q};
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_q) begin
            if (!diff[WIDTH]) begin
                hi_d = diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = shl[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
        end else begin
            {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end
    end

    assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is assigned with <= so all registers update together.
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (busy_q) begin
            cnt_q <= done_o ? '0 : cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

    // NOTE: datapath registers need no reset; they are always loaded by start_i before use.
    always_ff @(posedge clk) begin
        if (start_i) begin
            div_q <= div_i;
            hi_q  <= '0;
            lo_q  <= a_i;
            b_q   <= b_i;
        end else if (busy_q) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake; IDLE -> (BUSY) -> DONE -> IDLE.
// Define SEQ_ALU_MULDIV_EN to build the iterative MULU/DIVU unit and DivZero flag.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivZero
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] alu_res, sum, diff;
    logic             alu_ovf;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        sum     = A + B;
        diff    = A - B;
        case (ALUOperation)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_NOR:  alu_res = ~(A | B);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLL:  alu_res = B << shamt;
            OP_SRL:  alu_res = B >> shamt;
            OP_LUI:  alu_res = WIDTH'({B[15:0], 16'h0000});
            OP_SRA:  alu_res = $unsigned($signed(B) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, A < B};
            default: alu_res = '0;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    logic [WIDTH-1:0] hi_q, hi_d, md_lo, md_hi;
    logic             dz_q, dz_d, md_start, md_done;

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (reset),
        .start_i(md_start),
        .div_i  (ALUOperation == OP_DIVU),
        .a_i    (A),
        .b_i    (B),
        .done_o (md_done),
        .lo_o   (md_lo),
        .hi_o   (md_hi)
    );
`endif

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`ifdef SEQ_ALU_MULDIV_EN
        hi_d     = hi_q;
        dz_d     = dz_q;
        md_start = 1'b0;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = DONE;
                res_d   = alu_res;
                zero_d  = (alu_res == '0);
                ovf_d   = alu_ovf;
`ifdef SEQ_ALU_MULDIV_EN
                hi_d = '0;
                dz_d = 1'b0;
                if (ALUOperation == OP_MULU || (ALUOperation == OP_DIVU && B != '0)) begin
                    state_d  = BUSY;
                    md_start = 1'b1;
                end else if (ALUOperation == OP_DIVU) begin
                    res_d  = '1;
                    hi_d   = A;
                    dz_d   = 1'b1;
                    zero_d = 1'b0;
                end
`endif
            end
`ifdef SEQ_ALU_MULDIV_EN
            BUSY: if (md_done) begin
                state_d = DONE;
                res_d   = md_lo;
                hi_d    = md_hi;
                zero_d  = (md_lo == '0);
            end
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef SEQ_ALU_MULDIV_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            dz_q <= 1'b0;
        end else begin
            hi_q <= hi_d;
            dz_q <= dz_d;
        end
    end
    assign ResultHi = hi_q;
    assign DivZero  = dz_q;
`else
    assign ResultHi = '0;
    assign DivZero  = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign ALUResult = res_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32); expectations adapt to SEQ_ALU_MULDIV_EN.
module tb_seq_alu;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero;
        logic        ovf;
        logic        dz;
        logic [7:0]  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  ALUOperation = '0;
    logic [31:0] A = '0, B = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] ALUResult, ResultHi;
    logic        Zero, Overflow, DivZero;

    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_total = 0;

`ifdef SEQ_ALU_MULDIV_EN
    localparam int MD_LAT = 33;
`endif

    seq_alu #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALUOperation(ALUOperation),
        .A           (A),
        .B           (B),
        .shamt       (shamt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALUResult   (ALUResult),
        .ResultHi    (ResultHi),
        .Zero        (Zero),
        .Overflow    (Overflow),
        .DivZero     (DivZero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [31:0] res, input logic [31:0] hi,
                                input logic ovf, input logic dz, input int lat);
        exp_t e;
        e.res  = res;
        e.hi   = hi;
        e.zero = (res == 32'd0);
        e.ovf  = ovf;
        e.dz   = dz;
        e.lat  = 8'(lat);
        return e;
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("res=%h hi=%h z=%b v=%b dz=%b lat=%0d", e.res, e.hi, e.zero, e.ovf, e.dz, e.lat);
    endfunction

    // Reference model written from the opcode table, used for the random mix.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh);
        logic [31:0] r;
        logic [63:0] p;
        logic        v;
        r = 32'd0;
        v = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = ~(a | b);
            4'd3: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd4: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd5:  r = b << sh;
            4'd6:  r = b >> sh;
            4'd7:  r = {b[15:0], 16'h0000};
            4'd8:  r = $signed(b) >>> sh;
            4'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd10: r = (a < b) ? 32'd1 : 32'd0;
`ifdef SEQ_ALU_MULDIV_EN
            4'd11: begin p = {32'd0, a} * {32'd0, b}; return mk(p[31:0], p[63:32], 1'b0, 1'b0, MD_LAT); end
            4'd12: begin
                if (b == 32'd0) return mk(32'hFFFF_FFFF, a, 1'b0, 1'b1, 1);
                return mk(a / b, a % b, 1'b0, 1'b0, MD_LAT);
            end
`endif
            default: r = 32'd0;
        endcase
        return mk(r, 32'd0, v, 1'b0, 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, waits (bounded) for out_valid and optionally consumes it.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input bit consume, output exp_t obs);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 100) begin tick(); cyc++; end
        ALUOperation = op; A = a; B = b; shamt = sh;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 100) begin tick(); cyc++; end
        obs.res  = ALUResult;
        obs.hi   = ResultHi;
        obs.zero = Zero;
        obs.ovf  = Overflow;
        obs.dz   = DivZero;
        obs.lat  = out_valid ? 8'(cyc) : 8'hFF;
        if (consume) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
        exp_t obs, exp_v;
        issue(op, a, b, sh, 1'b1, obs);
        exp_v = sb_q.pop_front();
        n_total++;
        if (obs !== exp_v) $display("FAIL %s: got %s, want %s", name, fmt(obs), fmt(exp_v));
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_total++;
        if ({in_ready, out_valid, ALUResult, ResultHi, Zero, Overflow, DivZero} !== {1'b1, 1'b0, 67'd0})
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h hi=%h z=%b v=%b dz=%b, want rdy=1 rest 0",
                     in_ready, out_valid, ALUResult, ResultHi, Zero, Overflow, DivZero);
        else n_pass++;
        reset = 1'b1;
        tick();
        n_total++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_release: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_add_overflow();
        sb_q.push_back(mk(32'h8000_0000, 32'd0, 1'b1, 1'b0, 1));
        run("add_ovf", 4'd3, 32'h7FFF_FFFF, 32'd1, 5'd0);
        sb_q.push_back(mk(32'h0000_0000, 32'd0, 1'b0, 1'b0, 1));
        run("add_zero_wrap", 4'd3, 32'hFFFF_FFFF, 32'd1, 5'd0);
        sb_q.push_back(mk(32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0, 1));
        run("sub_ovf", 4'd4, 32'h8000_0000, 32'd1, 5'd0);
    endtask

    task automatic test_shifts();
        sb_q.push_back(mk(32'hF800_0000, 32'd0, 1'b0, 1'b0, 1));
        run("sra", 4'd8, 32'd0, 32'h8000_0000, 5'd4);
        sb_q.push_back(mk(32'h0800_0000, 32'd0, 1'b0, 1'b0, 1));
        run("srl", 4'd6, 32'd0, 32'h8000_0000, 5'd4);
        sb_q.push_back(mk(32'h8000_0000, 32'd0, 1'b0, 1'b0, 1));
        run("sll_31", 4'd5, 32'd0, 32'h0000_0003, 5'd31);
        sb_q.push_back(mk(32'hABCD_0000, 32'd0, 1'b0, 1'b0, 1));
        run("lui", 4'd7, 32'd0, 32'h1234_ABCD, 5'd0);
    endtask

    task automatic test_logic_compare();
        sb_q.push_back(mk(32'h0000_0F00, 32'd0, 1'b0, 1'b0, 1));
        run("and", 4'd0, 32'h0000_FF00, 32'h0F0F_0F0F, 5'd0);
        sb_q.push_back(mk(32'h0000_0000, 32'd0, 1'b0, 1'b0, 1));
        run("nor_zero", 4'd2, 32'hFFFF_0000, 32'h0000_FFFF, 5'd0);
        sb_q.push_back(mk(32'd1, 32'd0, 1'b0, 1'b0, 1));
        run("slt_signed", 4'd9, 32'hFFFF_FFFF, 32'd1, 5'd0);
        sb_q.push_back(mk(32'd0, 32'd0, 1'b0, 1'b0, 1));
        run("sltu_unsigned", 4'd10, 32'hFFFF_FFFF, 32'd1, 5'd0);
        sb_q.push_back(mk(32'd0, 32'd0, 1'b0, 1'b0, 1));
        run("undef_13", 4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
    endtask

    task automatic test_muldiv();
`ifdef SEQ_ALU_MULDIV_EN
        sb_q.push_back(mk(32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0, MD_LAT));
        run("mulu", 4'd11, 32'hFFFF_FFFF, 32'd2, 5'd0);
        sb_q.push_back(mk(32'd14, 32'd2, 1'b0, 1'b0, MD_LAT));
        run("divu", 4'd12, 32'd100, 32'd7, 5'd0);
        sb_q.push_back(mk(32'hFFFF_FFFF, 32'd100, 1'b0, 1'b1, 1));
        run("divu_by_zero", 4'd12, 32'd100, 32'd0, 5'd0);
`else
        sb_q.push_back(mk(32'd0, 32'd0, 1'b0, 1'b0, 1));
        run("mulu_disabled", 4'd11, 32'hFFFF_FFFF, 32'd2, 5'd0);
        sb_q.push_back(mk(32'd0, 32'd0, 1'b0, 1'b0, 1));
        run("divu_disabled", 4'd12, 32'd100, 32'd7, 5'd0);
        sb_q.push_back(mk(32'd0, 32'd0, 1'b0, 1'b0, 1));
        run("divu0_disabled", 4'd12, 32'd100, 32'd0, 5'd0);
`endif
    endtask

    task automatic test_done_hold();
        exp_t obs, exp_v;
        sb_q.push_back(mk(32'd11, 32'd0, 1'b0, 1'b0, 1));
        issue(4'd3, 32'd5, 32'd6, 5'd0, 1'b0, obs);
        exp_v = sb_q.pop_front();
        n_total++;
        if (obs !== exp_v) $display("FAIL hold_first: got %s, want %s", fmt(obs), fmt(exp_v));
        else n_pass++;
        ALUOperation = 4'd4; A = 32'd1; B = 32'd9;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if ({out_valid, in_ready, ALUResult, ResultHi, Zero, Overflow, DivZero} !==
                {1'b1, 1'b0, 32'd11, 32'd0, 3'b000})
                $display("FAIL hold_cycle%0d: got vld=%b rdy=%b res=%h hi=%h z=%b v=%b dz=%b, want vld=1 rdy=0 res=0000000b",
                         i, out_valid, in_ready, ALUResult, ResultHi, Zero, Overflow, DivZero);
            else n_pass++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_total++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL hold_release: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL hold_ignored_req: got vld=%b, want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_busy();
        bit seen;
        ALUOperation = 4'd11; A = 32'hFFFF_FFFF; B = 32'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        reset = 1'b0;
        #1;
        n_total++;
        if ({out_valid, ALUResult, ResultHi, Zero, Overflow, DivZero} !== 68'd0)
            $display("FAIL abort_outputs: got vld=%b res=%h hi=%h z=%b v=%b dz=%b, want all 0",
                     out_valid, ALUResult, ResultHi, Zero, Overflow, DivZero);
        else n_pass++;
        tick();
        reset = 1'b1;
        tick();
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL abort_ready: got rdy=%b, want 1", in_ready);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL abort_no_valid: got out_valid seen=%b, want 0", seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  sh;
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom();
            b  = (i % 6 == 5) ? 32'd0 : $urandom();
            sh = 5'($urandom_range(0, 31));
            sb_q.push_back(model(op, a, b, sh));
            run($sformatf("rand%0d_op%0d", i, op), op, a, b, sh);
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_shifts();
        test_logic_compare();
        test_muldiv();
        test_done_hold();
        test_reset_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
